// File: rtl/alu_issue_ctrl.sv
// ALU issue control: decodes RV64I ALU-class instructions into an ALU op code and two operands,
// then buffers them in a 2-entry FIFO presented to the ALU with valid/ready flow control.
module alu_issue_ctrl #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_valid,
    output logic              o_inst_ready,
    input  logic [INST_W-1:0] i_inst,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    output logic              o_alu_valid,
    input  logic              i_alu_ready,
    output logic [3:0]        o_ALUinst,
    output logic [DATA_W-1:0] o_ALU_in1,
    output logic [DATA_W-1:0] o_ALU_in2,
    output logic              o_illegal,
    output logic [7:0]        o_illegal_cnt
);

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcBr    = 7'b1100011;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011;
    localparam logic [3:0] AluSll = 4'b0100;
    localparam logic [3:0] AluSrl = 4'b0101;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluBne = 4'b0111;

    typedef enum logic [1:0] {SelRs2, SelImmI, SelImmS, SelShamt} in2_sel_e;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] shamt;

    logic              dec_legal;
    logic [3:0]        dec_op;
    in2_sel_e          dec_sel;
    logic [DATA_W-1:0] dec_in2;

    assign opcode = i_inst[6:0];
    assign funct3 = i_inst[14:12];
    assign funct7 = i_inst[31:25];
    assign imm_i  = {{(DATA_W-12){i_inst[31]}}, i_inst[31:20]};
    assign imm_s  = {{(DATA_W-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign shamt  = {{(DATA_W-6){1'b0}}, i_inst[25:20]};

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = AluAdd;
        dec_sel   = SelRs2;
        unique case (opcode)
            OpcOp: begin
                dec_sel = SelRs2;
                unique case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = AluAdd;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = AluSub;
                        end
                    end
                    3'b111: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = AluAnd;
                    end
                    3'b110: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = AluOr;
                    end
                    3'b100: begin
                        dec_legal = (funct7 == 7'b0000000);
                        dec_op    = AluXor;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpcOpImm: begin
                dec_sel = SelImmI;
                unique case (funct3)
                    3'b000: begin
                        dec_legal = 1'b1;
                        dec_op    = AluAdd;
                    end
                    3'b111: begin
                        dec_legal = 1'b1;
                        dec_op    = AluAnd;
                    end
                    3'b110: begin
                        dec_legal = 1'b1;
                        dec_op    = AluOr;
                    end
                    3'b100: begin
                        dec_legal = 1'b1;
                        dec_op    = AluXor;
                    end
                    // RV64 shifts use a 6-bit shamt, so only inst[31:26] must be zero
                    3'b001: begin
                        dec_legal = (i_inst[31:26] == 6'd0);
                        dec_op    = AluSll;
                        dec_sel   = SelShamt;
                    end
                    3'b101: begin
                        dec_legal = (i_inst[31:26] == 6'd0);
                        dec_op    = AluSrl;
                        dec_sel   = SelShamt;
                    end
                    default: dec_legal = 1'b0;
                endcase
            end
            OpcLoad: begin
                dec_legal = (funct3 == 3'b011);
                dec_op    = AluAdd;
                dec_sel   = SelImmI;
            end
            OpcStore: begin
                dec_legal = (funct3 == 3'b011);
                dec_op    = AluAdd;
                dec_sel   = SelImmS;
            end
            OpcBr: begin
                dec_sel = SelRs2;
                if (funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_op    = AluSub;
                end else if (funct3 == 3'b001) begin
                    dec_legal = 1'b1;
                    dec_op    = AluBne;
                end
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        dec_in2 = i_rs2_data;
        unique case (dec_sel)
            SelRs2:   dec_in2 = i_rs2_data;
            SelImmI:  dec_in2 = imm_i;
            SelImmS:  dec_in2 = imm_s;
            SelShamt: dec_in2 = shamt;
            default:  dec_in2 = i_rs2_data;
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [1:0]        count_q, count_d;
    logic [0:0]        wr_ptr_q, wr_ptr_d;
    logic [0:0]        rd_ptr_q, rd_ptr_d;
    logic [3:0]        op_q  [DEPTH];
    logic [DATA_W-1:0] in1_q [DEPTH];
    logic [DATA_W-1:0] in2_q [DEPTH];
    logic              illegal_q, illegal_d;
    logic [7:0]        illegal_cnt_q, illegal_cnt_d;

    logic accept;
    logic push;
    logic pop;

    assign o_inst_ready = (count_q < 2'd2);
    assign o_alu_valid  = (count_q != 2'd0);
    assign accept       = i_inst_valid & o_inst_ready;
    assign push         = accept & dec_legal;
    assign pop          = o_alu_valid & i_alu_ready;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Illegal encodings complete the handshake but are dropped; only the flag/counter record them
    always_comb begin
        illegal_d     = accept & ~dec_legal;
        illegal_cnt_d = illegal_cnt_q;
        if (illegal_d && (illegal_cnt_q != 8'hFF)) begin
            illegal_cnt_d = illegal_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q       <= 2'd0;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            illegal_q     <= 1'b0;
            illegal_cnt_q <= 8'd0;
        end else begin
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]  <= 4'd0;
                in1_q[i] <= '0;
                in2_q[i] <= '0;
            end
        end else if (push) begin
            op_q[wr_ptr_q]  <= dec_op;
            in1_q[wr_ptr_q] <= i_rs1_data;
            in2_q[wr_ptr_q] <= dec_in2;
        end
    end

    // Head is forced to zero when empty so stale entries never leak onto the ALU bus
    always_comb begin
        o_ALUinst = 4'd0;
        o_ALU_in1 = '0;
        o_ALU_in2 = '0;
        if (o_alu_valid) begin
            o_ALUinst = op_q[rd_ptr_q];
            o_ALU_in1 = in1_q[rd_ptr_q];
            o_ALU_in2 = in2_q[rd_ptr_q];
        end
    end

    assign o_illegal     = illegal_q;
    assign o_illegal_cnt = illegal_cnt_q;

endmodule
